// File: rtl/serial_shifter24_pkg.sv
// serial_shifter24_pkg: shared widths, shift op codes, FSM states and shift-amount clamp
package serial_shifter24_pkg;
    localparam int WIDTH   = 24;
    localparam int SHAMT_W = 5;
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;
    localparam logic [2:0] ALU_OP_SHIFT = 3'b110;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    function automatic logic [SHAMT_W-1:0] clamp_shamt(input logic [SHAMT_W-1:0] s);
        return (s > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : s;
    endfunction
endpackage

// File: rtl/serial_shifter24_shift_step.sv
// shift_step: combinational single-bit-position shift of a WIDTH-bit value by op
module shift_step
    import serial_shifter24_pkg::*;
(
    input  logic [WIDTH-1:0] v,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);
    always_comb
        y = (op == SH_SLL) ? {v[WIDTH-2:0], 1'b0} :
            (op == SH_SRL) ? {1'b0, v[WIDTH-1:1]} :
            (op == SH_SRA) ? {v[WIDTH-1], v[WIDTH-1:1]} : v;
endmodule

// File: rtl/serial_shifter24.sv
// serial_shifter24: iterative one-bit-per-clock SLL/SRL/SRA shifter with start/busy/done handshake
module serial_shifter24
    import serial_shifter24_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         shiftop,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shiftres
);
    state_t state, state_n;
    logic [WIDTH-1:0] r, r_n, stepped;
    logic [1:0] op, op_n;
    logic [SHAMT_W-1:0] cnt, cnt_n, n;
    assign n = clamp_shamt(shamt);
    shift_step u_step (.v(r), .op(op), .y(stepped));
    always_ff @(posedge clock)
        if (reset) begin
            state <= S_IDLE;
            r     <= '0;
            op    <= SH_SLL;
            cnt   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            op    <= op_n;
            cnt   <= cnt_n;
        end
    // Start is only honoured outside SHIFT; zero-step and reserved ops finish immediately.
    always_comb begin
        state_n = state;
        r_n     = r;
        op_n    = op;
        cnt_n   = cnt;
        if (state == S_SHIFT) begin
            r_n     = stepped;
            cnt_n   = cnt - 1'b1;
            state_n = (cnt == SHAMT_W'(1)) ? S_DONE : S_SHIFT;
        end else if (start) begin
            r_n     = a;
            op_n    = shiftop;
            cnt_n   = (shiftop == SH_RSV) ? '0 : n;
            state_n = (n == '0 || shiftop == SH_RSV) ? S_DONE : S_SHIFT;
        end
    end
    assign busy     = (state == S_SHIFT);
    assign done     = (state == S_DONE);
    assign shiftres = r;
endmodule
